// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction/flag inputs and datapath control bundle
interface multicycle_controller_if;
    logic [31:0] instr;
    logic        Zero;
    logic        cout;
    logic        overflow;
    logic        sign;
    logic [3:0]  ALUControl;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  AdrSrc;
    logic [2:0]  ImmSrc;
    logic        IRWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic        trap;
    logic [3:0]  state;

    modport master (
        input  instr, Zero, cout, overflow, sign,
        output ALUControl, ResultSrc, ALUSrcA, ALUSrcB, AdrSrc, ImmSrc,
               IRWrite, PCWrite, RegWrite, MemWrite, trap, state
    );

    modport slave (
        output instr, Zero, cout, overflow, sign,
        input  ALUControl, ResultSrc, ALUSrcA, ALUSrcB, AdrSrc, ImmSrc,
               IRWrite, PCWrite, RegWrite, MemWrite, trap, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM driving the datapath
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input logic clk,
    input logic reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
        S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR  = 4'd6,  S_EXECI   = 4'd7,
        S_ALUWB    = 4'd8,  S_BRANCH  = 4'd9,  S_JAL    = 4'd10, S_JALRADR = 4'd11,
        S_JALR     = 4'd12, S_LUI     = 4'd13, S_TRAP   = 4'd14, S_UNUSED  = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t state_q, state_next;
    logic   trap_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;
    logic       take;
    logic [3:0] alu_r, alu_i;
    logic       unused_instr_bits;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign bit30  = bus.instr[30];
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    // R-type and I-type share the funct3 map; only R-type lets bit 30 turn ADD into SUB.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub_sra);
        case (f3)
            3'b000:  alu_decode = sub_sra ? 4'b0001 : 4'b0000;
            3'b001:  alu_decode = 4'b0101;
            3'b010:  alu_decode = 4'b1000;
            3'b011:  alu_decode = 4'b1001;
            3'b100:  alu_decode = 4'b0100;
            3'b101:  alu_decode = sub_sra ? 4'b0111 : 4'b0110;
            3'b110:  alu_decode = 4'b0011;
            default: alu_decode = 4'b0010;
        endcase
    endfunction

    assign alu_r = alu_decode(funct3, bit30);
    assign alu_i = alu_decode(funct3, bit30 && (funct3 == 3'b101));

    always_comb begin
        case (funct3)
            3'b000:  take = bus.Zero;
            3'b001:  take = !bus.Zero;
            3'b100:  take = bus.sign ^ bus.overflow;
            3'b101:  take = !(bus.sign ^ bus.overflow);
            3'b110:  take = !bus.cout;
            3'b111:  take = bus.cout;
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= state_t'(RESET_STATE);
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            trap_q  <= trap_q | (state_next == S_TRAP);
        end
    end

    always_comb begin
        state_next     = state_q;
        bus.ALUControl = 4'b0000;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.AdrSrc     = 2'b00;
        bus.ImmSrc     = 3'b000;
        bus.IRWrite    = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.MemWrite   = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.IRWrite = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_next  = S_DECODE;
            end
            S_DECODE: begin
                bus.PCWrite = 1'b1;
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                case (opcode)
                    OP_BRANCH: bus.ImmSrc = 3'b010;
                    OP_JAL:    bus.ImmSrc = 3'b011;
                    OP_AUIPC:  bus.ImmSrc = 3'b100;
                    default:   bus.ImmSrc = 3'b000;
                endcase
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_OP:     state_next = S_EXECR;
                    OP_IMM:    state_next = S_EXECI;
                    OP_BRANCH: state_next = (funct3 == 3'b010 || funct3 == 3'b011) ? S_TRAP : S_BRANCH;
                    OP_JAL:    state_next = S_JAL;
                    OP_JALR:   state_next = S_JALRADR;
                    OP_LUI:    state_next = S_LUI;
                    OP_AUIPC:  state_next = S_ALUWB;
                    default:   state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = (opcode == OP_STORE) ? 3'b001 : 3'b000;
                state_next  = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.AdrSrc  = 2'b01;
                state_next  = S_MEMWB;
            end
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.ALUSrcA  = 2'b10;
                bus.ALUSrcB  = 2'b01;
                bus.ImmSrc   = 3'b001;
                bus.AdrSrc   = 2'b01;
                bus.MemWrite = 1'b1;
                state_next   = S_FETCH;
            end
            S_EXECR: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUControl = alu_r;
                state_next     = S_ALUWB;
            end
            S_EXECI: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = alu_i;
                state_next     = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
                state_next   = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUControl = 4'b0001;
                bus.PCWrite    = take;
                state_next     = S_FETCH;
            end
            S_JAL: begin
                bus.PCWrite = 1'b1;
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                state_next  = S_ALUWB;
            end
            S_JALRADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                state_next  = S_JALR;
            end
            S_JALR: begin
                bus.PCWrite = 1'b1;
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                state_next  = S_ALUWB;
            end
            S_LUI: begin
                bus.ImmSrc    = 3'b100;
                bus.ResultSrc = 2'b10;
                bus.RegWrite  = 1'b1;
                state_next    = S_FETCH;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_TRAP;
        endcase
        // Reset must never let a half-finished instruction commit anything.
        if (reset) begin
            bus.IRWrite  = 1'b0;
            bus.PCWrite  = 1'b0;
            bus.RegWrite = 1'b0;
            bus.MemWrite = 1'b0;
        end
    end

    assign bus.trap  = trap_q;
    assign bus.state = state_q;
endmodule
